// File: rtl/add_share_arb_pkg.sv
// Shared types for the shared-adder arbiter.
//   state_t : arbitration state (ARB = free round-robin, LOCKED = chained op in progress)
//   flags_t : per-beat adder flag bundle
package add_share_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic cout;
        logic neg;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/add_share_arb_add_core.sv
// Combinational carry-propagate adder built from per-bit propagate/generate terms.
// Ports:
//   a, b   in  WIDTH  operands (b already conditioned for subtract by the caller)
//   cin    in  1      carry in
//   sum    out WIDTH  a + b + cin modulo 2^WIDTH
//   flags  out        {cout, neg, ovf, zero} for this beat
module add_core
    import add_share_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output flags_t           flags
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign p[gi]   = a[gi] ^ b[gi];
            assign g[gi]   = a[gi] & b[gi];
            assign c[gi+1] = g[gi] | (p[gi] & c[gi]);
        end
    endgenerate

    assign sum = p ^ c[WIDTH-1:0];

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign flags.cout = c[WIDTH];
    assign flags.neg  = sum[WIDTH-1];
    assign flags.ovf  = c[WIDTH] ^ c[WIDTH-1];
    assign flags.zero = (sum == '0);

endmodule

// File: rtl/add_share_arb.sv
// Shares one adder between NREQ requesters with round-robin arbitration,
// valid/ready handshakes, a 1-entry registered response slot, subtract, and
// multi-beat carry-chained operations that lock the grant to one owner.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       per-requester handshake (at most one ready bit)
//   req_a/req_b               packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sub/req_last          subtract (first beat only) / final beat marker
//   rsp_valid/rsp_ready       response slot handshake
//   rsp_id, rsp_sum, rsp_cout, rsp_neg, rsp_ovf, rsp_zero, rsp_last  result of a beat
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
    input  logic [NREQ-1:0]       req_last,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_neg,
    output logic                  rsp_ovf,
    output logic                  rsp_zero,
    output logic                  rsp_last
);

    // Round-robin pick over a doubled request vector: the first set bit at or
    // after ptr, within one full lap, is the winner. Returns {found, index}.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
        logic [2*NREQ-1:0] dbl;
        logic [IDW:0]      res;
        dbl = {valid, valid};
        res = '0;
        // Descending scan so the lowest qualifying position wins.
        for (int k = 2*NREQ-1; k >= 0; k--) begin
            if (dbl[k] && (k >= int'(ptr)) && (k < int'(ptr) + NREQ)) begin
                res = {1'b1, IDW'(k % NREQ)};
            end
        end
        return res;
    endfunction

    state_t           state, state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   owner;
    logic             carry_q;
    logic             sub_q;

    logic             slot_free;
    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic             transfer;
    logic [IDW:0]     pick;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_sub;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    flags_t           add_flags;
    flags_t           rsp_flags;

    assign slot_free = !rsp_valid | rsp_ready;
    assign pick      = rr_pick(req_valid, rr_ptr);
    assign transfer  = grant_found & slot_free;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a non-last beat locks, a last beat releases.
    always_comb begin
        state_next = state;
        if (transfer) begin
            state_next = req_last[grant_id] ? ARB : LOCKED;
        end
    end

    // Grant / ready outputs. While locked only the owner is eligible.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        req_ready   = '0;
        if (state == LOCKED) begin
            grant_id    = owner;
            grant_found = req_valid[owner];
        end else begin
            grant_id    = pick[IDW-1:0];
            grant_found = pick[IDW];
        end
        if (grant_found && slot_free) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Operand steering: first beat takes sub from the request, later beats
    // reuse the latched sub and chain the previous carry.
    always_comb begin
        add_a   = req_a[grant_id*WIDTH +: WIDTH];
        add_sub = (state == LOCKED) ? sub_q   : req_sub[grant_id];
        add_cin = (state == LOCKED) ? carry_q : req_sub[grant_id];
        add_b   = req_b[grant_id*WIDTH +: WIDTH] ^ {WIDTH{add_sub}};
    end

    add_core #(.WIDTH(WIDTH)) u_add_core (
        .a     (add_a),
        .b     (add_b),
        .cin   (add_cin),
        .sum   (add_sum),
        .flags (add_flags)
    );

    // Chain bookkeeping and response slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            owner     <= '0;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_flags <= '0;
            rsp_last  <= 1'b0;
        end else begin
            if (transfer) begin
                carry_q   <= add_flags.cout;
                rsp_valid <= 1'b1;
                rsp_id    <= grant_id;
                rsp_sum   <= add_sum;
                rsp_flags <= add_flags;
                rsp_last  <= req_last[grant_id];
                if (req_last[grant_id]) begin
                    rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                end else begin
                    owner <= grant_id;
                    sub_q <= add_sub;
                end
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_cout = rsp_flags.cout;
    assign rsp_neg  = rsp_flags.neg;
    assign rsp_ovf  = rsp_flags.ovf;
    assign rsp_zero = rsp_flags.zero;

endmodule
